scc_stereo_mixer: RTL and testbench
===================================

SCC_STEREO_MIXER -- requirements
Module: scc_stereo_mixer

Interface
REQ-001 SHALL have parameter CH_NUM, default 5, channel count, legal range 1..8.
REQ-002 SHALL have parameter SAMPLE_W, default 8, signed wave sample width.
REQ-003 SHALL have parameter OUT_W, default 11, mix output width; must be at least SAMPLE_W+ceil(log2(CH_NUM)).
REQ-004 SHALL have parameter ADD_OFFSET, default 1; 1 = unsigned mix, each term +2^(SAMPLE_W-1); 0 = signed two's-complement mix.
REQ-005 clk  in  1  clock.
REQ-006 nreset  in  1  reset, synchronous, active-low.
REQ-007 enable  in  1  clock enable; all state holds when 0.
REQ-008 cpu_busy  in  1  CPU owns wave RAM this cycle.
REQ-009 slot  out  3  channel index whose sample is being requested.
REQ-010 sample_req  out  1  wave RAM read for slot, combinational.
REQ-011 sample_in  in  SAMPLE_W  signed RAM data, valid one enabled cycle after sample_req.
REQ-012 volume  in  4*CH_NUM  per-channel volume; channel k at bits [4k+3:4k].
REQ-013 ch_enable  in  CH_NUM  per-channel enable.
REQ-014 pan_l  in  CH_NUM  channel routed to left.
REQ-015 pan_r  in  CH_NUM  channel routed to right.
REQ-016 left_out  out  OUT_W  registered left mix.
REQ-017 right_out  out  OUT_W  registered right mix.
REQ-018 frame_strobe  out  1  one-cycle pulse when the outputs update.

Function
REQ-019 sample_req SHALL equal enable & ~cpu_busy.
REQ-020 On each enabled, non-busy cycle, slot SHALL advance 0,1,..,CH_NUM-1 and wrap to 0.
REQ-021 When cpu_busy=1, slot SHALL hold.
REQ-022 Request stage, every enabled cycle: req_q <= sample_req; tag_q <= slot.
REQ-023 Scale stage, enabled cycle with req_q=1:
- s1 <= (sample_in * volume[tag_q]) arithmetic-shifted right by 4, truncated to SAMPLE_W bits (signed x unsigned, floor);
- s1_tag <= tag_q; s1_v <= 1.
REQ-024 On an enabled cycle with req_q=0, s1_v SHALL be cleared.
REQ-025 Capture SHALL depend only on req_q, so a busy cycle still captures the data of a preceding request.
REQ-026 Contribution per side: c = s1 when ch_enable and the pan bit of s1_tag are both 1, else 0.
REQ-027 Offset conversion: ADD_OFFSET=1 uses c + 2^(SAMPLE_W-1), zero-extended to OUT_W; ADD_OFFSET=0 sign-extends c to OUT_W.
REQ-028 Accumulate stage, enabled cycle with s1_v=1, per side: s1_tag=0 loads acc with the term; any other tag adds the term to acc, modulo 2^OUT_W.
REQ-029 When s1_tag=CH_NUM-1, the accumulate stage SHALL also:
- load out <= acc + term (or the term alone when CH_NUM=1);
- pulse frame_strobe for one cycle.
REQ-030 frame_strobe SHALL be 0 in every other cycle, including all cycles with enable=0.
REQ-031 Latency: a sample requested for channel CH_NUM-1 on enabled cycle t SHALL appear on the outputs after the 2nd following enabled cycle.
REQ-032 Frame period SHALL be CH_NUM enabled, non-busy cycles.
REQ-033 volume, ch_enable and pan changes SHALL take effect for the next sample processed; no frame-level latching.

Reset
REQ-034 With nreset=0 at a clock edge, regardless of enable, the block SHALL clear:
- slot, req_q, tag_q, s1, s1_tag, s1_v and both accumulators;
- left_out, right_out and frame_strobe.
REQ-035 Reset mid-frame SHALL discard the partial frame; the first request after release SHALL be slot 0.

Verification (CH_NUM=5, SAMPLE_W=8, OUT_W=11)
REQ-036 Reset: hold nreset=0 over a frame -> left_out=right_out=0, frame_strobe=0, slot=0; first request after release has slot=0.
REQ-037 All channels enabled and panned both ways, sample_in=127, volume=15, ADD_OFFSET=1 -> each term 119+128=247; left_out=right_out=1235; strobe every 5 enabled cycles.
REQ-038 Pan and mask: only ch0 enabled with pan_l=1, pan_r=0, sample -128, volume 15, ADD_OFFSET=1 -> left_out=8+4*128=520, right_out=640.
REQ-039 cpu_busy held for 3 cycles mid-frame, constant stimulus -> slot holds, results identical to the no-busy case, strobe spacing 8 cycles.
REQ-040 ADD_OFFSET=0, all channels sample -128, volume 15, panned both ways -> left_out=right_out=0x5A8 (-600).
REQ-041 Assert nreset at slot 3, release after 2 cycles -> outputs 0 until the next full frame completes, which carries the correct sum.

Source files
------------

// File: rtl/scc_stereo_mixer.sv
// Stereo wave mixer: time-multiplexes CH_NUM wave RAM reads, scales each sample by
// its channel volume and accumulates panned left/right sums, one frame per CH_NUM requests.
module scc_stereo_mixer #(
  parameter int CH_NUM     = 5,
  parameter int SAMPLE_W   = 8,
  parameter int OUT_W      = 11,
  parameter int ADD_OFFSET = 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  cpu_busy,
  output logic [2:0]            slot,
  output logic                  sample_req,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic [4*CH_NUM-1:0]   volume,
  input  logic [CH_NUM-1:0]     ch_enable,
  input  logic [CH_NUM-1:0]     pan_l,
  input  logic [CH_NUM-1:0]     pan_r,
  output logic [OUT_W-1:0]      left_out,
  output logic [OUT_W-1:0]      right_out,
  output logic                  frame_strobe
);

  localparam logic [2:0] LAST_SLOT = 3'(CH_NUM - 1);

  logic                        req_q;
  logic [2:0]                  tag_q;
  logic signed [SAMPLE_W-1:0]  s1;
  logic [2:0]                  s1_tag;
  logic                        s1_v;
  logic [OUT_W-1:0]            acc_l;
  logic [OUT_W-1:0]            acc_r;

  logic [3:0]                  tag_vol;
  logic                        sel_en;
  logic                        sel_l;
  logic                        sel_r;
  logic signed [SAMPLE_W+4:0]  product;
  logic signed [SAMPLE_W-1:0]  scaled;
  logic signed [SAMPLE_W-1:0]  c_l;
  logic signed [SAMPLE_W-1:0]  c_r;
  logic [OUT_W-1:0]            term_l;
  logic [OUT_W-1:0]            term_r;
  logic [OUT_W-1:0]            sum_l;
  logic [OUT_W-1:0]            sum_r;

  assign sample_req = enable & ~cpu_busy;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    tag_vol = '0;
    sel_en  = 1'b0;
    sel_l   = 1'b0;
    sel_r   = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (tag_q == 3'(k)) tag_vol = volume[4*k +: 4];
      if (s1_tag == 3'(k)) begin
        sel_en = ch_enable[k];
        sel_l  = pan_l[k];
        sel_r  = pan_r[k];
      end
    end
  end

  // Volume is unsigned: a zero MSB keeps the signed multiply from treating 8..15 as negative.
  assign product = (SAMPLE_W+5)'($signed(sample_in)) * (SAMPLE_W+5)'($signed({1'b0, tag_vol}));
  assign scaled  = product[SAMPLE_W+3:4];

  assign c_l = (sel_en & sel_l) ? s1 : '0;
  assign c_r = (sel_en & sel_r) ? s1 : '0;

  if (ADD_OFFSET != 0) begin : g_offset
    localparam logic [SAMPLE_W-1:0] BIAS = {1'b1, {(SAMPLE_W-1){1'b0}}};
    logic [SAMPLE_W-1:0] biased_l;
    logic [SAMPLE_W-1:0] biased_r;
    // Adding half-scale to a signed sample never overflows SAMPLE_W unsigned bits.
    assign biased_l = c_l + BIAS;
    assign biased_r = c_r + BIAS;
    assign term_l   = OUT_W'(biased_l);
    assign term_r   = OUT_W'(biased_r);
  end else begin : g_signed
    assign term_l = OUT_W'(c_l);
    assign term_r = OUT_W'(c_r);
  end

  // Tag 0 starts a fresh frame, which also covers CH_NUM=1 where the term alone is output.
  assign sum_l = (s1_tag == 3'd0) ? term_l : acc_l + term_l;
  assign sum_r = (s1_tag == 3'd0) ? term_r : acc_r + term_r;

  // NOTE: nreset is sampled only on the clock edge, so it stays out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      slot         <= '0;
      req_q        <= 1'b0;
      tag_q        <= '0;
      s1           <= '0;
      s1_tag       <= '0;
      s1_v         <= 1'b0;
      acc_l        <= '0;
      acc_r        <= '0;
      left_out     <= '0;
      right_out    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (enable) begin
        req_q <= sample_req;
        tag_q <= slot;
        if (sample_req) slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;

        // Capture follows req_q alone, so data requested before a busy cycle is not lost.
        if (req_q) begin
          s1     <= scaled;
          s1_tag <= tag_q;
          s1_v   <= 1'b1;
        end else begin
          s1_v   <= 1'b0;
        end

        if (s1_v) begin
          acc_l <= sum_l;
          acc_r <= sum_r;
          if (s1_tag == LAST_SLOT) begin
            left_out     <= sum_l;
            right_out    <= sum_r;
            frame_strobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scc_stereo_mixer.sv
// Bench for scc_stereo_mixer: a frame-level arithmetic model checked every cycle against
// an unsigned-mix and a signed-mix instance, plus hand-computed frame values.
module tb_scc_stereo_mixer;

  localparam int CH = 5;
  localparam int SW = 8;
  localparam int OW = 11;

  logic            clk = 1'b0;
  logic            nreset;
  logic            enable;
  logic            cpu_busy;
  logic [2:0]      slot;
  logic [2:0]      slot_s;
  logic            sample_req;
  logic            sample_req_s;
  logic [SW-1:0]   sample_in = '0;
  logic [4*CH-1:0] volume;
  logic [CH-1:0]   ch_enable;
  logic [CH-1:0]   pan_l;
  logic [CH-1:0]   pan_r;
  logic [OW-1:0]   left_out;
  logic [OW-1:0]   right_out;
  logic [OW-1:0]   left_s;
  logic [OW-1:0]   right_s;
  logic            strobe;
  logic            strobe_s;

  logic signed [SW-1:0] ram [CH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  scc_stereo_mixer #(.CH_NUM(CH), .SAMPLE_W(SW), .OUT_W(OW), .ADD_OFFSET(1)) u_dut (
    .clk(clk), .nreset(nreset), .enable(enable), .cpu_busy(cpu_busy),
    .slot(slot), .sample_req(sample_req), .sample_in(sample_in),
    .volume(volume), .ch_enable(ch_enable), .pan_l(pan_l), .pan_r(pan_r),
    .left_out(left_out), .right_out(right_out), .frame_strobe(strobe)
  );

  scc_stereo_mixer #(.CH_NUM(CH), .SAMPLE_W(SW), .OUT_W(OW), .ADD_OFFSET(0)) u_dut_s (
    .clk(clk), .nreset(nreset), .enable(enable), .cpu_busy(cpu_busy),
    .slot(slot_s), .sample_req(sample_req_s), .sample_in(sample_in),
    .volume(volume), .ch_enable(ch_enable), .pan_l(pan_l), .pan_r(pan_r),
    .left_out(left_s), .right_out(right_s), .frame_strobe(strobe_s)
  );

  // Wave RAM with one-cycle read latency; the read only fires on an accepted request.
  always @(posedge clk) if (enable && !cpu_busy) sample_in <= ram[slot];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int term(int k, bit right, bit offs);
    int  p;
    int  sc;
    bit  route;
    p     = int'(ram[k]) * int'(volume[4*k +: 4]);
    sc    = int'($floor(real'(p) / 16.0));
    route = ch_enable[k] && (right ? pan_r[k] : pan_l[k]);
    return (route ? sc : 0) + (offs ? 128 : 0);
  endfunction

  function automatic logic [OW-1:0] mix(bit right, bit offs);
    int s = 0;
    for (int k = 0; k < CH; k++) s += term(k, right, offs);
    return OW'(s);
  endfunction

  int            exp_slot = 0;
  int            pend[$];
  logic [OW-1:0] exp_l = '0, exp_r = '0, exp_ls = '0, exp_rs = '0;
  bit            exp_strobe = 1'b0;
  bit            started = 1'b0;

  // A completed frame shows up two enabled cycles after its last request.
  initial forever begin
    @(posedge clk);
    cyc++;
    started = 1'b1;
    if (!nreset) begin
      exp_slot   = 0;
      pend.delete();
      exp_strobe = 1'b0;
      exp_l = '0; exp_r = '0; exp_ls = '0; exp_rs = '0;
    end else begin
      exp_strobe = 1'b0;
      if (enable) begin
        foreach (pend[i]) pend[i]--;
        if (pend.size() > 0 && pend[0] == 0) begin
          void'(pend.pop_front());
          exp_l  = mix(1'b0, 1'b1);
          exp_r  = mix(1'b1, 1'b1);
          exp_ls = mix(1'b0, 1'b0);
          exp_rs = mix(1'b1, 1'b0);
          exp_strobe = 1'b1;
        end
        if (!cpu_busy) begin
          if (exp_slot == CH - 1) pend.push_back(2);
          exp_slot = (exp_slot + 1) % CH;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("slot", slot, exp_slot);
      check("slot_s", slot_s, exp_slot);
      check("sample_req", sample_req, enable & ~cpu_busy);
      check("frame_strobe", strobe, exp_strobe);
      check("frame_strobe_s", strobe_s, exp_strobe);
      check("left_out", left_out, exp_l);
      check("right_out", right_out, exp_r);
      check("left_s", left_s, exp_ls);
      check("right_s", right_s, exp_rs);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_strobe(output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (strobe === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!seen) check("strobe_timeout", 0, 1);
  endtask

  task automatic set_uniform(input int sample, input logic [3:0] vol,
                             input logic [CH-1:0] en, input logic [CH-1:0] pl,
                             input logic [CH-1:0] pr);
    for (int k = 0; k < CH; k++) ram[k] = SW'(sample);
    volume    = {CH{vol}};
    ch_enable = en;
    pan_l     = pl;
    pan_r     = pr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, n;
    nreset   = 1'b0;
    enable   = 1'b1;
    cpu_busy = 1'b0;
    set_uniform(127, 4'd15, 5'h1f, 5'h1f, 5'h1f);

    // Reset held over more than a frame.
    step(8);
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_strobe", strobe, 0);
    check("rst_slot", slot, 0);
    nreset = 1'b1;
    @(negedge clk);
    check("first_req_slot", slot, 0);
    check("first_req", sample_req, 1);

    // Full-scale positive, everything routed: 5 * (119 + 128).
    wait_strobe(t1);
    check("full_left", left_out, 1235);
    check("full_right", right_out, 1235);
    wait_strobe(t2);
    check("full_gap", t2 - t1, 5);

    // Only channel 0 live, left only, -128 at full volume.
    step(1);
    nreset = 1'b0;
    set_uniform(-128, 4'd15, 5'h01, 5'h01, 5'h00);
    step(2);
    nreset = 1'b1;
    wait_strobe(t1);
    check("mask_left", left_out, 520);
    check("mask_right", right_out, 640);
    check("mask_left_s", left_s, 1928);
    check("mask_right_s", right_s, 0);

    // Signed mix of five -120 terms: -600 = 0x5A8.
    step(1);
    nreset = 1'b0;
    set_uniform(-128, 4'd15, 5'h1f, 5'h1f, 5'h1f);
    step(2);
    nreset = 1'b1;
    wait_strobe(t1);
    check("signed_left_s", left_s, 11'h5A8);
    check("signed_right_s", right_s, 11'h5A8);
    check("signed_left_u", left_out, 40);

    // Distinct samples/volumes/pans; cpu_busy stretches one frame by 3 cycles.
    step(1);
    nreset = 1'b0;
    ram[0] = 8'sd10;  ram[1] = -8'sd20; ram[2] = 8'sd30; ram[3] = -8'sd40; ram[4] = 8'sd50;
    volume    = {4'd0, 4'd1, 4'd4, 4'd8, 4'd15};
    ch_enable = 5'h1f;
    pan_l     = 5'b10101;
    pan_r     = 5'b01011;
    step(2);
    nreset = 1'b1;
    wait_strobe(t1);
    check("mixed_left", left_out, 656);
    check("mixed_right", right_out, 636);
    check("mixed_left_s", left_s, 16);
    check("mixed_right_s", right_s, 2044);
    step(2);
    cpu_busy = 1'b1;
    step(3);
    cpu_busy = 1'b0;
    wait_strobe(t2);
    check("busy_gap", t2 - t1, 8);
    check("busy_left", left_out, 656);
    check("busy_right", right_out, 636);

    // Clock-enable gap: state holds, no strobe while disabled.
    step(1);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    wait_strobe(t1);
    check("gap_left", left_out, 656);

    // Reset at slot 3 discards the partial frame.
    n = 0;
    while (slot !== 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_slot3", slot, 3);
    nreset = 1'b0;
    step(2);
    nreset = 1'b1;
    check("midrst_left", left_out, 0);
    check("midrst_right", right_out, 0);
    wait_strobe(t1);
    check("midrst_frame_left", left_out, 656);
    check("midrst_frame_right", right_out, 636);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
